// File: rtl/fetch_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_stage
// Description : Single-issue instruction fetch and decode stage.
//               Issues word-aligned fetch requests from a program counter,
//               captures the returned instruction word together with its PC
//               and the fully decoded fields in one registered bundle, and
//               holds that bundle while the downstream stage stalls.
//               A redirect (pc_load_i) has priority over everything except
//               reset.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   1   rising-edge clock for all state
//   nRst          in   1   synchronous, active-low reset
//   imem_req_o    out  1   fetch request, imem_addr_o valid while high
//   imem_addr_o   out  32  word-aligned fetch address (current PC)
//   imem_ack_i    in   1   imem_rdata_i valid for imem_addr_o this cycle
//   imem_rdata_i  in   32  fetched instruction word
//   pc_load_i     in   1   redirect request (taken branch / jump)
//   pc_target_i   in   32  redirect address (low two bits ignored)
//   stall_i       in   1   downstream cannot accept the held instruction
//   id_valid_o    out  1   held bundle is a valid instruction
//   id_pc_o       out  32  PC of the held instruction
//   id_instr_o    out  32  raw held instruction
//   i_type_o      out  3   R=0 I=1 S=2 SB=3 UJ=4 U=5 illegal=7
//   ctrl_key_o    out  17  {instr[31:25], instr[14:12], instr[6:0]}
//   rs1_o/rs2_o/rd_o out 5 register specifiers
//   imm_o         out  32  sign-extended immediate for the decoded type
//   illegal_o     out  1   held opcode not recognised (qualified by valid)
// ============================================================================
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nRst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        pc_load_i,
    input  logic [31:0] pc_target_i,
    input  logic        stall_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_instr_o,
    output logic [2:0]  i_type_o,
    output logic [16:0] ctrl_key_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic [31:0] imm_o,
    output logic        illegal_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_BOOT  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    localparam logic [2:0] c_T_R   = 3'd0;
    localparam logic [2:0] c_T_I   = 3'd1;
    localparam logic [2:0] c_T_S   = 3'd2;
    localparam logic [2:0] c_T_SB  = 3'd3;
    localparam logic [2:0] c_T_UJ  = 3'd4;
    localparam logic [2:0] c_T_U   = 3'd5;
    localparam logic [2:0] c_T_ILL = 3'd7;

    localparam logic [6:0] c_OP_OP     = 7'b0110011;
    localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    localparam logic [31:0] c_PC_STEP  = 32'd4;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]  state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q,    id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [2:0]  i_type_q,   i_type_d;
    logic [16:0] ctrl_key_q, ctrl_key_d;
    logic [4:0]  rs1_q,      rs1_d;
    logic [4:0]  rs2_q,      rs2_d;
    logic [4:0]  rd_q,       rd_d;
    logic [31:0] imm_q,      imm_d;
    logic        illegal_q,  illegal_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic        w_req;
    logic        w_accept;
    logic [6:0]  w_opcode;
    logic [2:0]  w_dec_type;
    logic        w_dec_illegal;
    logic [31:0] w_dec_imm;
    logic [31:0] w_target_aligned;
    logic        w_unused;

    // The PC is always word aligned, so the low target bits are dropped.
    assign w_target_aligned = {pc_target_i[31:2], 2'b00};
    assign w_unused         = ^pc_target_i[1:0];

    // A returned word is only taken when it answers a live request and no
    // redirect is pending; a redirect in the same cycle makes it stale.
    assign w_accept = w_req & imem_ack_i & ~pc_load_i;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q <= c_ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (pc_load_i) begin
            // Redirect wins over stall and over the HOLD state.
            state_d = c_ST_FETCH;
        end else begin
            case (state_q)
                c_ST_BOOT:  state_d = c_ST_FETCH;
                c_ST_FETCH: begin
                    if (id_valid_q && stall_i) begin
                        state_d = c_ST_HOLD;
                    end
                end
                c_ST_HOLD: begin
                    if (!stall_i) begin
                        state_d = c_ST_FETCH;
                    end
                end
                default:    state_d = c_ST_BOOT;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------------
    // In FETCH the request is withdrawn as soon as the held slot is full and
    // blocked, so no word can return that would have nowhere to go.
    always_comb begin
        w_req = 1'b0;
        case (state_q)
            c_ST_FETCH: w_req = ~(id_valid_q & stall_i);
            default:    w_req = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Decode of the incoming word (registered only on accept, so the held
    // fields always belong to the held instruction)
    // ------------------------------------------------------------------------
    assign w_opcode = imem_rdata_i[6:0];

    always_comb begin
        w_dec_type    = c_T_ILL;
        w_dec_illegal = 1'b0;
        case (w_opcode)
            c_OP_OP:     w_dec_type = c_T_R;
            c_OP_OPIMM,
            c_OP_LOAD,
            c_OP_JALR:   w_dec_type = c_T_I;
            c_OP_STORE:  w_dec_type = c_T_S;
            c_OP_BRANCH: w_dec_type = c_T_SB;
            c_OP_JAL:    w_dec_type = c_T_UJ;
            c_OP_LUI,
            c_OP_AUIPC:  w_dec_type = c_T_U;
            default: begin
                w_dec_type    = c_T_ILL;
                w_dec_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_dec_imm = 32'd0;
        case (w_dec_type)
            c_T_I:  w_dec_imm = {{20{imem_rdata_i[31]}}, imem_rdata_i[31:20]};
            c_T_S:  w_dec_imm = {{20{imem_rdata_i[31]}}, imem_rdata_i[31:25],
                                 imem_rdata_i[11:7]};
            c_T_SB: w_dec_imm = {{19{imem_rdata_i[31]}}, imem_rdata_i[31],
                                 imem_rdata_i[7], imem_rdata_i[30:25],
                                 imem_rdata_i[11:8], 1'b0};
            c_T_UJ: w_dec_imm = {{11{imem_rdata_i[31]}}, imem_rdata_i[31],
                                 imem_rdata_i[19:12], imem_rdata_i[20],
                                 imem_rdata_i[30:21], 1'b0};
            c_T_U:  w_dec_imm = {imem_rdata_i[31:12], 12'd0};
            default: w_dec_imm = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------------
    always_comb begin
        pc_d       = pc_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        i_type_d   = i_type_q;
        ctrl_key_d = ctrl_key_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        imm_d      = imm_q;
        illegal_d  = illegal_q;

        if (pc_load_i) begin
            pc_d       = w_target_aligned;
            id_valid_d = 1'b0;
        end else if (w_accept) begin
            // 32-bit add wraps 32'hFFFF_FFFC back to zero.
            pc_d       = pc_q + c_PC_STEP;
            id_valid_d = 1'b1;
            id_pc_d    = pc_q;
            id_instr_d = imem_rdata_i;
            i_type_d   = w_dec_type;
            ctrl_key_d = {imem_rdata_i[31:25], imem_rdata_i[14:12], w_opcode};
            rs1_d      = imem_rdata_i[19:15];
            rs2_d      = imem_rdata_i[24:20];
            rd_d       = imem_rdata_i[11:7];
            imm_d      = w_dec_imm;
            illegal_d  = w_dec_illegal;
        end else if (!stall_i) begin
            // Downstream consumed the held word and nothing replaced it.
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            pc_q       <= {RESET_PC[31:2], 2'b00};
            id_valid_q <= 1'b0;
            id_pc_q    <= 32'd0;
            id_instr_q <= 32'd0;
            i_type_q   <= c_T_R;
            ctrl_key_q <= 17'd0;
            rs1_q      <= 5'd0;
            rs2_q      <= 5'd0;
            rd_q       <= 5'd0;
            imm_q      <= 32'd0;
            illegal_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            i_type_q   <= i_type_d;
            ctrl_key_q <= ctrl_key_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            imm_q      <= imm_d;
            illegal_q  <= illegal_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign imem_req_o  = w_req;
    assign imem_addr_o = pc_q;
    assign id_valid_o  = id_valid_q;
    assign id_pc_o     = id_pc_q;
    assign id_instr_o  = id_instr_q;
    assign i_type_o    = i_type_q;
    assign ctrl_key_o  = ctrl_key_q;
    assign rs1_o       = rs1_q;
    assign rs2_o       = rs2_q;
    assign rd_o        = rd_q;
    assign imm_o       = imm_q;
    // Decode fields survive a redirect, so illegal is gated by validity.
    assign illegal_o   = illegal_q & id_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_decode_stage
// Description : Self-checking bench for fetch_decode_stage: directed
//               scenarios followed by randomized traffic against a
//               behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_decode_stage;

    logic        clk = 1'b0;
    logic        nRst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [2:0]  i_type;
    logic [16:0] ctrl_key;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        illegal;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] c_X_SUB  = 32'h40B5_0533;
    localparam logic [31:0] c_X_BEQ  = 32'hFE00_0EE3;
    localparam logic [31:0] c_X_ADDI = 32'hFFF0_0093;
    localparam logic [31:0] c_X_NOP  = 32'h0000_0013;
    localparam logic [31:0] c_X_BAD  = 32'h0000_007F;

    fetch_decode_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .nRst         (nRst),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_ack_i   (imem_ack),
        .imem_rdata_i (imem_rdata),
        .pc_load_i    (pc_load),
        .pc_target_i  (pc_target),
        .stall_i      (stall),
        .id_valid_o   (id_valid),
        .id_pc_o      (id_pc),
        .id_instr_o   (id_instr),
        .i_type_o     (i_type),
        .ctrl_key_o   (ctrl_key),
        .rs1_o        (rs1),
        .rs2_o        (rs2),
        .rd_o         (rd),
        .imm_o        (imm),
        .illegal_o    (illegal)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs on the falling edge, then settle.
    task automatic drive(input logic n, input logic ack, input logic [31:0] rdat,
                         input logic ld, input logic [31:0] tgt, input logic st);
        @(negedge clk);
        nRst = n; imem_ack = ack; imem_rdata = rdat;
        pc_load = ld; pc_target = tgt; stall = st;
        #1;
    endtask

    // Reference decode from the instruction-set rules: returns {type, imm}.
    function automatic logic [34:0] ref_decode(input logic [31:0] ins);
        logic [2:0] t;
        int         v;
        logic [31:0] im;
        case (ins[6:0])
            7'b0110011:                         t = 3'd0;
            7'b0010011, 7'b0000011, 7'b1100111: t = 3'd1;
            7'b0100011:                         t = 3'd2;
            7'b1100011:                         t = 3'd3;
            7'b1101111:                         t = 3'd4;
            7'b0110111, 7'b0010111:             t = 3'd5;
            default:                            t = 3'd7;
        endcase
        v = 0;
        im = 32'd0;
        case (t)
            3'd1: begin v = int'(ins[31:20]); if (ins[31]) v = v - 4096; im = v; end
            3'd2: begin v = int'({ins[31:25], ins[11:7]}); if (ins[31]) v = v - 4096; im = v; end
            3'd3: begin
                v = int'({ins[31], ins[7], ins[30:25], ins[11:8]}) * 2;
                if (ins[31]) v = v - 8192;
                im = v;
            end
            3'd4: begin
                v = int'({ins[31], ins[19:12], ins[20], ins[30:21]}) * 2;
                if (ins[31]) v = v - 2097152;
                im = v;
            end
            3'd5: im = ins & 32'hFFFF_F000;
            default: im = 32'd0;
        endcase
        return {t, im};
    endfunction

    task automatic test_reset();
        drive(1'b0, 1'b1, 32'h1234_5678, 1'b1, 32'h0000_0040, 1'b1);
        drive(1'b0, 1'b1, 32'h1234_5678, 1'b1, 32'h0000_0040, 1'b1);
        n_checks++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b expected 0", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== 32'd0) $display("FAIL rst_addr: got %h expected 0", imem_addr); else n_pass++;
        n_checks++; if ({id_valid, illegal} !== 2'b00) $display("FAIL rst_valid_illegal: got %b expected 00", {id_valid, illegal}); else n_pass++;
        n_checks++; if ({id_pc, id_instr, imm} !== 96'd0) $display("FAIL rst_words: got %h expected 0", {id_pc, id_instr, imm}); else n_pass++;
        n_checks++; if ({i_type, ctrl_key, rs1, rs2, rd} !== 35'd0) $display("FAIL rst_fields: got %h expected 0", {i_type, ctrl_key, rs1, rs2, rd}); else n_pass++;
    endtask

    task automatic test_boot_decode();
        drive(1'b1, 1'b1, c_X_SUB, 1'b0, 32'd0, 1'b0);   // BOOT cycle
        n_checks++; if (imem_req !== 1'b0) $display("FAIL boot_req: got %b expected 0", imem_req); else n_pass++;
        drive(1'b1, 1'b1, c_X_SUB, 1'b0, 32'd0, 1'b0);   // first FETCH
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'd0}) $display("FAIL fetch0: got %b/%h expected 1/0", imem_req, imem_addr); else n_pass++;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL fetch0_valid: got %b expected 0", id_valid); else n_pass++;
        drive(1'b1, 1'b1, c_X_BEQ, 1'b0, 32'd0, 1'b0);
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'd4}) $display("FAIL fetch4: got %b/%h expected 1/4", imem_req, imem_addr); else n_pass++;
        n_checks++; if ({id_valid, id_pc, id_instr} !== {1'b1, 32'd0, c_X_SUB}) $display("FAIL sub_hold: got %b/%h/%h expected 1/0/%h", id_valid, id_pc, id_instr, c_X_SUB); else n_pass++;
        n_checks++; if ({i_type, ctrl_key} !== {3'd0, 17'b01000000000110011}) $display("FAIL sub_type_key: got %0d/%b expected 0/01000000000110011", i_type, ctrl_key); else n_pass++;
        n_checks++; if ({rs1, rs2, rd} !== {5'd10, 5'd11, 5'd10}) $display("FAIL sub_regs: got %0d/%0d/%0d expected 10/11/10", rs1, rs2, rd); else n_pass++;
        n_checks++; if ({imm, illegal} !== 33'd0) $display("FAIL sub_imm: got %h/%b expected 0/0", imm, illegal); else n_pass++;
        drive(1'b1, 1'b1, c_X_ADDI, 1'b0, 32'd0, 1'b0);
        n_checks++; if (imem_addr !== 32'd8) $display("FAIL fetch8: got %h expected 8", imem_addr); else n_pass++;
        n_checks++; if ({id_pc, i_type, imm} !== {32'd4, 3'd3, 32'hFFFF_FFFC}) $display("FAIL beq: got %h/%0d/%h expected 4/3/fffffffc", id_pc, i_type, imm); else n_pass++;
    endtask

    task automatic test_stall_hold();
        logic [31:0] held_pc;
        drive(1'b1, 1'b1, c_X_NOP, 1'b0, 32'd0, 1'b1);
        held_pc = 32'd8;
        n_checks++; if ({id_valid, id_pc, i_type, imm} !== {1'b1, held_pc, 3'd1, 32'hFFFF_FFFF}) $display("FAIL addi: got %b/%h/%0d/%h expected 1/8/1/ffffffff", id_valid, id_pc, i_type, imm); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL stall_req0: got %b expected 0", imem_req); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, c_X_NOP, 1'b0, 32'd0, 1'b1);
            n_checks++; if (imem_req !== 1'b0) $display("FAIL hold_req[%0d]: got %b expected 0", k, imem_req); else n_pass++;
            n_checks++; if ({id_valid, id_pc, id_instr} !== {1'b1, held_pc, c_X_ADDI}) $display("FAIL hold_ids[%0d]: got %b/%h/%h expected 1/%h/%h", k, id_valid, id_pc, id_instr, held_pc, c_X_ADDI); else n_pass++;
        end
        drive(1'b1, 1'b1, c_X_NOP, 1'b0, 32'd0, 1'b0);   // release, still in HOLD
        n_checks++; if ({imem_req, id_valid} !== 2'b01) $display("FAIL release: got req=%b valid=%b expected req=0 valid=1", imem_req, id_valid); else n_pass++;
        drive(1'b1, 1'b1, c_X_NOP, 1'b0, 32'd0, 1'b0);
        n_checks++; if ({imem_req, imem_addr, id_valid} !== {1'b1, held_pc + 32'd4, 1'b0}) $display("FAIL resume: got %b/%h/%b expected 1/%h/0", imem_req, imem_addr, id_valid, held_pc + 32'd4); else n_pass++;
    endtask

    task automatic test_redirect();
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0000_0103, 1'b1);
        n_checks++; if ({id_valid, id_pc} !== {1'b1, 32'd12}) $display("FAIL pre_redirect: got %b/%h expected 1/c", id_valid, id_pc); else n_pass++;
        drive(1'b1, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h0000_0200, 1'b0);
        n_checks++; if ({id_valid, imem_addr} !== {1'b0, 32'h100}) $display("FAIL redirect1: got %b/%h expected 0/100", id_valid, imem_addr); else n_pass++;
        n_checks++; if (imem_req !== 1'b1) $display("FAIL redirect1_req: got %b expected 1", imem_req); else n_pass++;
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        n_checks++; if ({id_valid, illegal, imem_addr} !== {2'b00, 32'h200}) $display("FAIL redirect2: got %b/%b/%h expected 0/0/200", id_valid, illegal, imem_addr); else n_pass++;
    endtask

    task automatic test_wrap_illegal();
        drive(1'b1, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        drive(1'b1, 1'b1, c_X_BAD, 1'b0, 32'd0, 1'b0);
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) $display("FAIL top_addr: got %b/%h expected 1/fffffffc", imem_req, imem_addr); else n_pass++;
        // Reset lands with an ack pending: it must not be captured.
        drive(1'b0, 1'b1, c_X_SUB, 1'b0, 32'd0, 1'b0);
        n_checks++; if (imem_addr !== 32'd0) $display("FAIL wrap: got %h expected 0", imem_addr); else n_pass++;
        n_checks++; if ({id_valid, id_pc, i_type, illegal, imm} !== {1'b1, 32'hFFFF_FFFC, 3'd7, 1'b1, 32'd0}) $display("FAIL illegal: got %b/%h/%0d/%b/%h expected 1/fffffffc/7/1/0", id_valid, id_pc, i_type, illegal, imm); else n_pass++;
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        n_checks++; if ({imem_req, imem_addr, id_valid, illegal} !== 35'd0) $display("FAIL midrst_ctl: got %b/%h/%b/%b expected 0/0/0/0", imem_req, imem_addr, id_valid, illegal); else n_pass++;
        n_checks++; if ({id_pc, id_instr, imm, i_type, ctrl_key, rs1, rs2, rd} !== 131'd0) $display("FAIL midrst_fields: got %h expected 0", {id_pc, id_instr, imm, i_type, ctrl_key, rs1, rs2, rd}); else n_pass++;
    endtask

    task automatic test_random();
        // Model: phase 0=boot,1=fetch,2=hold; held instruction kept as raw word.
        int          phase;
        logic [31:0] m_pc, m_id_pc, m_instr;
        logic        m_valid, m_cleared;
        logic        e_req, acc;
        logic [34:0] dec;
        logic [2:0]  e_type;
        logic [31:0] e_imm;
        logic        n, ack, ld, st;
        logic [31:0] rdat, tgt;
        logic [6:0]  ops [0:8];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111};
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        phase = 0; m_pc = 32'd0; m_id_pc = 32'd0; m_instr = 32'd0;
        m_valid = 1'b0; m_cleared = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            n    = ($urandom_range(0, 99) >= 2);
            ack  = ($urandom_range(0, 9) < 7);
            ld   = ($urandom_range(0, 9) == 0);
            st   = ($urandom_range(0, 9) < 3);
            rdat = $urandom();
            if ($urandom_range(0, 10) < 9) rdat[6:0] = ops[$urandom_range(0, 8)];
            tgt  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
            drive(n, ack, rdat, ld, tgt, st);

            e_req = (phase == 1) && !(m_valid && st);
            dec = ref_decode(m_instr);
            e_type = m_cleared ? 3'd0 : dec[34:32];
            e_imm  = m_cleared ? 32'd0 : dec[31:0];
            n_checks++; if ({imem_req, imem_addr} !== {e_req, m_pc}) $display("FAIL rnd_fetch c%0d: got %b/%h expected %b/%h", cyc, imem_req, imem_addr, e_req, m_pc); else n_pass++;
            n_checks++; if ({id_valid, id_pc, id_instr} !== {m_valid, m_id_pc, m_instr}) $display("FAIL rnd_id c%0d: got %b/%h/%h expected %b/%h/%h", cyc, id_valid, id_pc, id_instr, m_valid, m_id_pc, m_instr); else n_pass++;
            n_checks++; if ({i_type, imm} !== {e_type, e_imm}) $display("FAIL rnd_dec c%0d: got %0d/%h expected %0d/%h", cyc, i_type, imm, e_type, e_imm); else n_pass++;
            n_checks++; if ({ctrl_key, rs1, rs2, rd} !== {m_instr[31:25], m_instr[14:12], m_instr[6:0], m_instr[19:15], m_instr[24:20], m_instr[11:7]}) $display("FAIL rnd_fields c%0d: got %h/%0d/%0d/%0d for %h", cyc, ctrl_key, rs1, rs2, rd, m_instr); else n_pass++;
            n_checks++; if (illegal !== (m_valid && e_type == 3'd7)) $display("FAIL rnd_illegal c%0d: got %b expected %b", cyc, illegal, m_valid && e_type == 3'd7); else n_pass++;

            acc = e_req && ack && !ld;
            if (!n) begin
                phase = 0; m_pc = 32'd0; m_valid = 1'b0; m_id_pc = 32'd0;
                m_instr = 32'd0; m_cleared = 1'b1;
            end else if (ld) begin
                m_pc = tgt & 32'hFFFF_FFFC; m_valid = 1'b0; phase = 1;
            end else begin
                if (phase == 0)                     phase = 1;
                else if (phase == 1 && m_valid && st) phase = 2;
                else if (phase == 2 && !st)         phase = 1;
                if (acc) begin
                    m_valid = 1'b1; m_id_pc = m_pc; m_instr = rdat;
                    m_cleared = 1'b0; m_pc = m_pc + 32'd4;
                end else if (!st) begin
                    m_valid = 1'b0;
                end
            end
        end
    endtask

    initial begin
        nRst = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
        pc_load = 1'b0; pc_target = 32'd0; stall = 1'b0;
        test_reset();
        test_boot_decode();
        test_stall_hold();
        test_redirect();
        test_wrap_illegal();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_decode_stage.md
FETCH_DECODE_STAGE -- requirements
Module: fetch_decode_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded by reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 nRst  in  1  reset, synchronous, active-low.
REQ-004 imem_req  out  1  fetch request; the address is valid while high.
REQ-005 imem_addr  out  32  word-aligned fetch address (current PC).
REQ-006 imem_ack  in  1  imem_rdata valid for imem_addr this cycle; meaningful only while imem_req is high.
REQ-007 imem_rdata  in  32  fetched instruction word.
REQ-008 pc_load  in  1  redirect request (branch or jump taken).
REQ-009 pc_target  in  32  redirect address.
REQ-010 stall  in  1  downstream cannot accept the held instruction this cycle.
REQ-011 id_valid  out  1  registered outputs hold a valid instruction.
REQ-012 id_pc  out  32  PC of the held instruction.
REQ-013 id_instr  out  32  raw held instruction.
REQ-014 i_type  out  3  instruction type: R=0, I=1, S=2, SB=3, UJ=4, U=5, illegal=7.
REQ-015 ctrl_key  out  17  {instr[31:25], instr[14:12], instr[6:0]}; this is the control-logic key.
REQ-016 rs1, rs2, rd  out  5 each  instr[19:15], instr[24:20], instr[11:7].
REQ-017 imm  out  32  sign-extended immediate for i_type.
REQ-018 illegal  out  1  held opcode is not recognized.

Function
REQ-019 The FSM SHALL have three states: BOOT, FETCH and HOLD.
REQ-020 BOOT SHALL move to FETCH unconditionally after one cycle, with imem_req=0 in BOOT.
REQ-021 In FETCH, imem_req SHALL be 1 unless id_valid=1 and stall=1.
REQ-022 In FETCH with id_valid=1 and stall=1, the FSM SHALL go to HOLD.
REQ-023 In HOLD, imem_req SHALL be 0, and the FSM SHALL return to FETCH in the first cycle stall=0.
REQ-024 Accept condition: imem_req=1, imem_ack=1, pc_load=0.
- On accept, the block SHALL register imem_rdata, the PC and all decode fields next edge.
- On accept, id_valid SHALL be set to 1 and pc SHALL advance by 4 (mod 2^32, wraps 32'hFFFF_FFFC to 0).
REQ-025 With no accept and stall=0, id_valid SHALL clear to 0 next edge; when stall=1, all id_* outputs SHALL hold.
REQ-026 pc_load SHALL have priority over everything, including stall:
- next edge: pc = {pc_target[31:2], 2'b00}, id_valid = 0, state = FETCH;
- any imem_ack in the same cycle SHALL be discarded.
REQ-027 Back-to-back throughput SHALL be one instruction per cycle while ack=1 and stall=0.
REQ-028 Fetch-to-id_valid latency SHALL be one cycle.
REQ-029 Opcode-to-i_type decode:
- 0110011 -> R;
- 0010011, 0000011, 1100111 -> I;
- 0100011 -> S;
- 1100011 -> SB;
- 1101111 -> UJ;
- 0110111, 0010111 -> U;
- any other opcode -> 7, with illegal=1.
REQ-030 Immediate generation by type:
- I: sext(instr[31:20]);
- S: sext({instr[31:25], instr[11:7]});
- SB: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
- UJ: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
- U: {instr[31:12], 12'b0};
- R or illegal: 0.
REQ-031 Decode fields SHALL be registered together with id_instr; the outputs SHALL never mix two instructions.
REQ-032 illegal SHALL be qualified by id_valid; when id_valid=0, illegal SHALL be 0.

Reset
REQ-033 When nRst=0 at a clock edge, the block SHALL load state=BOOT and pc=RESET_PC.
REQ-034 When nRst=0 at a clock edge, id_valid, id_pc, id_instr, ctrl_key, rs1, rs2, rd, imm and illegal SHALL load 0, and i_type SHALL load 0.
REQ-035 During and after reset, imem_req SHALL be 0 until the first FETCH cycle; reset SHALL override pc_load and stall.
REQ-036 Reset mid-transaction SHALL discard any pending ack, with no partial capture.

Verification
REQ-037 The bench SHALL cover the following directed scenarios:
- Reset release, RESET_PC=0, ack tied 1, stall=0 -> imem_req rises 1 cycle after reset; imem_addr 0,4,8; id_valid rises 1 cycle after first ack.
- rdata=32'h40B50533 (sub a0,a0,a1) -> i_type=0, ctrl_key=17'b01000000000110011, rs1=10, rs2=11, rd=10, imm=0.
- rdata=32'hFE000EE3 (SB, offset -4) -> i_type=3, imm=32'hFFFF_FFFC; rdata=32'hFFF00093 -> i_type=1, imm=32'hFFFF_FFFF.
- Stall held 3 cycles with id_valid=1 -> HOLD; imem_req=0; id_* constant; on stall=0, next fetch resumes at the held id_pc+4.
- pc_load=1, pc_target=32'h0000_0103, stall=1, ack=1 in the same cycle -> next cycle id_valid=0, imem_addr=32'h0000_0100; that cycle's data is dropped.
- pc=32'hFFFF_FFFC accepted -> next imem_addr=0; rdata=32'h0000007F -> i_type=7, illegal=1; nRst=0 mid-stream -> all outputs 0 next edge.
